fft_input_loader: RTL and testbench
===================================

# fft_input_loader

Sequencing controller for the serial input path of the radix-2 FFT. It gates a `width`-bit right-shift register (serial in, LSB-first) and counts `width` accepted bits per sample. It then writes each completed sample into FFT input memory at its bit-reversed index, and repeats for `points` samples per frame. It sits between the serial sample source and the FFT buffer, and signals frame completion to the FFT sequencer.

## Interface
- `width`, 4, bits per sample (≥2).
- `points`, 8, samples per frame (power of 2, ≥2).
- `addr_w`, 3, log2(`points`).

- `clk`  in  1  rising-edge clock.
- `clr`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a frame. Sampled only in IDLE.
- `s_in`  in  1  serial data bit. Passed through to the shift register unchanged.
- `s_valid`  in  1  `s_in` carries a valid bit this cycle.
- `s_ready`  out  1  loader accepts a bit this cycle.
- `sh_en`  out  1  shift-register enable: `s_valid & s_ready` (combinational).
- `sh_clr`  out  1  synchronous clear to the shift register.
- `wr_en`  out  1  sample word valid toward memory.
- `mem_ready`  in  1  memory accepts the write this cycle.
- `wr_addr`  out  `addr_w`  bit-reversed sample index.
- `busy`  out  1  high in any state except IDLE.
- `done`  out  1  one-cycle pulse at frame end.

## Operation
- FSM states: IDLE, CLEAR, SHIFT, WRITE, DONE.
- **IDLE**
  - `s_ready`=0, `busy`=0.
  - `start`=1 → CLEAR.
- **CLEAR** (exactly 1 cycle)
  - `sh_clr`=1; `bit_cnt` and `smp_cnt` load 0.
  - → SHIFT.
- **SHIFT**
  - `s_ready`=1.
  - Each accepted bit (`s_valid`=1) increments `bit_cnt`.
  - Accepting the bit with `bit_cnt`==`width`-1 → WRITE, and `bit_cnt` returns to 0.
  - `s_valid`=0 → hold state, no shift.
- **WRITE**
  - `s_ready`=0, `sh_en`=0, `wr_en`=1, `wr_addr`=bitrev(`smp_cnt`).
  - Shift-register contents are stable here: the first bit received sits in `dout[0]`.
  - Hold until `mem_ready`=1. The write completes on that cycle.
  - Write completes with `smp_cnt`==`points`-1 → DONE.
  - Otherwise `smp_cnt`+1 → SHIFT.
  - No clear between samples: `width` shifts fully overwrite the register.
- **DONE**
  - `done`=1 for one cycle, `busy`=1.
  - → IDLE.
- `start` outside IDLE is ignored and not queued.
- Bit reversal: `wr_addr`[k] = `smp_cnt`[`addr_w`-1-k].
- `bit_cnt` width is ceil(log2(`width`)); it never exceeds `width`-1.
- `smp_cnt` wraps naturally at `points` and never exceeds `points`-1.

## Timing
- Reset (`clr`=1, asynchronous), effective immediately at any point, mid-frame included:
  - State → IDLE; `bit_cnt`=0, `smp_cnt`=0.
  - `s_ready`, `sh_en`, `sh_clr`, `wr_en`, `busy`, `done` = 0; `wr_addr`=0.
  - A partial frame is discarded; no write is issued.
- `start` high at edge n: CLEAR during cycle n+1, first bit accepted no earlier than cycle n+2.
- With no stalls, each sample takes `width` SHIFT cycles plus 1 WRITE cycle.
- Frame latency from `start` edge to `done` pulse: 2 + `points`·(`width`+1) cycles (42 at the defaults).
- Source and memory stalls add cycles one for one.
- `s_valid` held high during WRITE: no bit is consumed (`s_ready`=0), so the source must hold `s_in`.
- `start` and `clr` high together: `clr` wins.
- `start` high in DONE: ignored; a new `start` is sampled only once IDLE is reached.

## Test plan
- **Reset:** assert `clr` mid-SHIFT at sample 3 → all outputs 0 in the same cycle. `start` after release → CLEAR, then `smp_cnt`=0, `wr_addr`=0.
- **Nominal frame:** defaults, `s_valid`=1 and `mem_ready`=1 throughout, serial samples 0..7 LSB-first.
  - `wr_en` pulses 8 times with `wr_addr` sequence 0,4,2,6,1,5,3,7.
  - Captured words equal 0..7.
  - `done` arrives 42 cycles after the `start` edge.
- **Source stall:** drop `s_valid` for 3 cycles after bit 2 of sample 5 → `sh_en`=0 during the gap, word unchanged, `done` delayed by exactly 3 cycles.
- **Memory backpressure:** hold `mem_ready`=0 for 4 cycles in WRITE of sample 1 → `wr_en`=1 and `wr_addr`=4 held stable, `s_ready`=0, no bits lost.
- **Ignored start:** pulse `start` mid-frame and again in DONE → no restart, exactly 8 writes, single `done` pulse.
- **Parameter sweep:** `width`=6, `points`=16, `addr_w`=4 → `wr_addr` sequence 0,8,4,12,…,15; `done` after 2+16·7=114 cycles.

Source files
------------

// File: rtl/fft_input_loader.sv
`timescale 1ns/1ps
// Serial-to-FFT-buffer load sequencer: gates a width-bit shift register, writes each sample at its bit-reversed index.
// Frame takes 2+points*(width+1) cycles unstalled; s_valid gaps and mem_ready stalls each add one cycle.
module fft_input_loader #(
  parameter int width  = 4,
  parameter int points = 8,
  parameter int addr_w = 3
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic              s_in,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              sh_en,
  output logic              sh_clr,
  output logic              wr_en,
  input  logic              mem_ready,
  output logic [addr_w-1:0] wr_addr,
  output logic              busy,
  output logic              done
);

  localparam int BW = $clog2(width);
  localparam logic [BW-1:0]     BIT_LAST = BW'(width - 1);
  localparam logic [addr_w-1:0] SMP_LAST = addr_w'(points - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SHIFT,
    ST_WRITE,
    ST_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [addr_w-1:0]   smp_cnt_q, smp_cnt_d;
  logic [addr_w-1:0]   smp_rev;

  // The data bit goes straight to the external shift register; the loader never inspects it.
  logic s_in_unused;
  assign s_in_unused = s_in;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      smp_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      smp_cnt_q <= smp_cnt_d;
    end
  end

  always_comb begin
    smp_rev = '0;
    for (int k = 0; k < addr_w; k++) begin
      smp_rev[k] = smp_cnt_q[addr_w-1-k];
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    smp_cnt_d = smp_cnt_q;
    s_ready   = 1'b0;
    sh_clr    = 1'b0;
    wr_en     = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        sh_clr    = 1'b1;
        bit_cnt_d = '0;
        smp_cnt_d = '0;
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        s_ready = 1'b1;
        if (s_valid) begin
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            state_d   = ST_WRITE;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      ST_WRITE: begin
        // No clear between samples: width shifts fully overwrite the register.
        wr_en = 1'b1;
        if (mem_ready) begin
          if (smp_cnt_q == SMP_LAST) begin
            state_d = ST_DONE;
          end else begin
            smp_cnt_d = smp_cnt_q + 1'b1;
            state_d   = ST_SHIFT;
          end
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign sh_en   = s_valid & s_ready;
  assign wr_addr = wr_en ? smp_rev : '0;

endmodule

// File: tb/tb_fft_input_loader.sv
`timescale 1ns/1ps
// Randomised bench for fft_input_loader: default instance plus a width=6/points=16 instance,
// checked against a transaction-level model of source, shift register and memory.
module tb_fft_input_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clr, start, sel, s_in, s_valid, mem_ready;
  logic start_a, start_b;
  logic s_ready_a, sh_en_a, sh_clr_a, wr_en_a, busy_a, done_a;
  logic [2:0] wr_addr_a;
  logic s_ready_b, sh_en_b, sh_clr_b, wr_en_b, busy_b, done_b;
  logic [3:0] wr_addr_b;

  assign start_a = start & ~sel;
  assign start_b = start & sel;

  fft_input_loader u_dut_a (
    .clk(clk), .clr(clr), .start(start_a), .s_in(s_in), .s_valid(s_valid),
    .s_ready(s_ready_a), .sh_en(sh_en_a), .sh_clr(sh_clr_a), .wr_en(wr_en_a),
    .mem_ready(mem_ready), .wr_addr(wr_addr_a), .busy(busy_a), .done(done_a)
  );

  fft_input_loader #(.width(6), .points(16), .addr_w(4)) u_dut_b (
    .clk(clk), .clr(clr), .start(start_b), .s_in(s_in), .s_valid(s_valid),
    .s_ready(s_ready_b), .sh_en(sh_en_b), .sh_clr(sh_clr_b), .wr_en(wr_en_b),
    .mem_ready(mem_ready), .wr_addr(wr_addr_b), .busy(busy_b), .done(done_b)
  );

  logic o_s_ready, o_sh_en, o_sh_clr, o_wr_en, o_busy, o_done;
  logic [3:0] o_wr_addr;
  assign o_s_ready = sel ? s_ready_b : s_ready_a;
  assign o_sh_en   = sel ? sh_en_b   : sh_en_a;
  assign o_sh_clr  = sel ? sh_clr_b  : sh_clr_a;
  assign o_wr_en   = sel ? wr_en_b   : wr_en_a;
  assign o_busy    = sel ? busy_b    : busy_a;
  assign o_done    = sel ? done_b    : done_a;
  assign o_wr_addr = sel ? wr_addr_b : {1'b0, wr_addr_a};

  int checks = 0;
  int errors = 0;
  int data[16];
  int gap[96];
  int mstall[16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int bitrev(input int v, input int aw);
    int r = 0;
    for (int k = 0; k < aw; k++) begin
      if (v[aw-1-k]) r |= (1 << k);
    end
    return r;
  endfunction

  task automatic clear_stalls();
    for (int i = 0; i < 96; i++) gap[i] = 0;
    for (int i = 0; i < 16; i++) mstall[i] = 0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_s_ready"}, o_s_ready, 0);
    chk({tag, "_sh_en"},   o_sh_en,   0);
    chk({tag, "_sh_clr"},  o_sh_clr,  0);
    chk({tag, "_wr_en"},   o_wr_en,   0);
    chk({tag, "_busy"},    o_busy,    0);
    chk({tag, "_done"},    o_done,    0);
    chk({tag, "_wr_addr"}, o_wr_addr, 0);
  endtask

  // One frame; the expected done cycle follows from the frame formula plus the stalls the
  // bench itself inserts (source gaps only between bits of a sample, memory waits per write).
  task automatic run_frame(input int W, input int P, input int AW, input int abort_k,
                           input bit ign_start);
    int exp_done, k, b, gap_left, widx, mwait, n_done, sr, stalls;
    bit aborted;
    stalls = 0;
    for (int i = 1; i < P*W; i++) if (i % W != 0) stalls += gap[i];
    for (int i = 0; i < P; i++) stalls += mstall[i];
    exp_done = 2 + P*(W+1) + stalls;
    k = 0; b = 0; gap_left = 0; widx = 0; mwait = 0; n_done = 0; sr = 0; aborted = 0;
    @(posedge clk); #1 start = 1'b1;
    while (k < exp_done + 3) begin
      @(posedge clk); #1;
      start = ign_start && (k + 1 == 10 || k + 1 == exp_done);
      if (b < P*W && gap_left == 0) begin
        s_valid = 1'b1;
        s_in    = 1'((data[b/W] >> (b%W)) & 1);
      end else begin
        s_valid = (b >= P*W) ? 1'($urandom % 2) : 1'b0;
        s_in    = 1'($urandom % 2);
        if (b < P*W) gap_left--;
      end
      if (o_wr_en) mem_ready = (mwait >= ((widx < P) ? mstall[widx] : 0));
      else         mem_ready = 1'($urandom % 2);

      @(negedge clk);
      k++;
      chk("sh_en_is_valid_and_ready", o_sh_en, s_valid & o_s_ready);
      chk("sh_clr_only_in_clear", o_sh_clr, k == 1);
      if (k == 1) chk("clear_not_ready", o_s_ready, 0);
      if (k == 2) chk("first_shift_ready", o_s_ready, 1);
      chk("busy", o_busy, k <= exp_done);
      chk("done_timing", o_done, k == exp_done);
      if (o_done) n_done++;
      if (o_wr_en) begin
        chk("wr_addr", o_wr_addr, bitrev(widx, AW));
        chk("write_not_ready", o_s_ready, 0);
        if (mem_ready) begin
          chk("word", sr & ((1 << W) - 1), (widx < P) ? data[widx] : -1);
          widx++;
          mwait = 0;
        end else begin
          mwait++;
        end
      end
      if (o_sh_clr)     sr = 0;
      else if (o_sh_en) sr = (sr >> 1) | (int'(s_in) << (W-1));
      if (o_sh_en) begin
        b++;
        gap_left = (b < P*W && b % W != 0) ? gap[b] : 0;
      end
      if (abort_k != 0 && k == abort_k) begin
        #2 clr = 1'b1;
        #1 check_all_zero("async_reset");
        start = 1'b0; s_valid = 1'b0;
        @(posedge clk); #1 clr = 1'b0;
        aborted = 1;
        break;
      end
    end
    start = 1'b0;
    s_valid = 1'b0;
    if (!aborted) begin
      chk("n_writes", widx, P);
      chk("n_bits", b, P*W);
      chk("n_done", n_done, 1);
    end
  endtask

  initial begin
    clr = 1'b1; start = 1'b0; sel = 1'b0; s_in = 1'b0; s_valid = 1'b0; mem_ready = 1'b0;
    #1 check_all_zero("reset_a");
    chk("reset_b_busy", busy_b, 0);
    chk("reset_b_wr_en", wr_en_b, 0);
    repeat (2) @(posedge clk);
    #1 clr = 1'b0;

    clear_stalls();
    for (int i = 0; i < 16; i++) data[i] = i % 16;
    run_frame(4, 8, 3, 0, 0);

    run_frame(4, 8, 3, 18, 0);
    run_frame(4, 8, 3, 0, 0);

    gap[5*4+3] = 3;
    run_frame(4, 8, 3, 0, 0);
    clear_stalls();

    mstall[1] = 4;
    run_frame(4, 8, 3, 0, 0);
    clear_stalls();

    for (int i = 0; i < 8; i++) data[i] = $urandom % 16;
    run_frame(4, 8, 3, 0, 1);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 8; i++) data[i] = $urandom % 16;
      for (int i = 0; i < 32; i++) gap[i] = ($urandom % 4 == 0) ? $urandom_range(1, 3) : 0;
      for (int i = 0; i < 8; i++) mstall[i] = ($urandom % 3 == 0) ? $urandom_range(1, 4) : 0;
      run_frame(4, 8, 3, 0, 0);
    end

    sel = 1'b1;
    clear_stalls();
    for (int i = 0; i < 16; i++) data[i] = $urandom % 64;
    run_frame(6, 16, 4, 0, 0);
    for (int i = 0; i < 16; i++) data[i] = $urandom % 64;
    for (int i = 0; i < 96; i++) gap[i] = ($urandom % 5 == 0) ? $urandom_range(1, 3) : 0;
    for (int i = 0; i < 16; i++) mstall[i] = ($urandom % 3 == 0) ? $urandom_range(1, 4) : 0;
    run_frame(6, 16, 4, 0, 1);
    sel = 1'b0;

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
